// File: rtl/unified_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_pkg
// Shared definitions for the unified memory arbiter:
//   - default address / data widths (match the core's ISIZE / DSIZE)
//   - encoding of the read-response owner register
// ---------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 16;

    // Who receives the memory read data in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage : unified_mem_arbiter_pkg

// File: rtl/unified_mem_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_sat_counter
// Saturating up-counter (the arbiter's sat_counter building block).
// Counts up by one on each clock with inc high, sticks at MAX.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous clear, active-low
//   clr  - synchronous clear (has priority over inc)
//   inc  - count enable
//   cnt  - current count
// ---------------------------------------------------------------------------
module unified_mem_arbiter_sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : unified_mem_arbiter_sat_counter

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port, 1-cycle-read-latency memory between the fetch
// port (F, read only) and the data port (D, read/write).
// One command per cycle is granted combinationally; the read data is
// steered to its owner one cycle later. D normally wins contention, but
// after D_BURST_MAX consecutive D grants with F waiting, F is forced in.
// Ports:
//   clk, rst                         - clock, async active-low reset
//   f_req/f_addr -> f_gnt            - fetch command, accepted same cycle
//   f_rvalid/f_rdata                 - fetch read response (T+1)
//   d_req/d_wen/d_addr/d_wdata->d_gnt - data command, accepted same cycle
//   d_rvalid/d_rdata                 - data read response (reads only)
//   mem_wen/mem_addr/mem_wdata       - memory command
//   mem_rdata                        - memory read data (cycle after address)
//   stall_f/stall_d                  - request pending but not granted
//   f_stall_cnt/d_stall_cnt          - saturating stall-cycle counters
// ---------------------------------------------------------------------------
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int D_BURST_MAX = 3,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          stall_f,
    output logic          stall_d,
    output logic [CW-1:0] f_stall_cnt,
    output logic [CW-1:0] d_stall_cnt
);

    // Burst counter only has to reach 7.
    localparam int         BW        = 3;
    localparam logic [2:0] BURST_MAX = 3'(D_BURST_MAX);

    logic [BW-1:0] burst_cnt;
    logic          f_win;
    logic          d_win;
    owner_e        resp_owner_q;
    owner_e        resp_owner_d;

    // ---------------------------------------------------------------- arbitration
    // F wins when alone, or when D has used up its burst allowance.
    always_comb begin
        f_win = f_req && (!d_req || (burst_cnt == BURST_MAX));
        d_win = d_req && !f_win;
    end

    assign f_gnt   = f_win;
    assign d_gnt   = d_win;
    assign stall_f = f_req && !f_win;
    assign stall_d = d_req && !d_win;

    // ---------------------------------------------------------------- memory command
    // With no request the address mux rests on the D address.
    assign mem_addr  = f_win ? f_addr : d_addr;
    assign mem_wdata = d_wdata;
    assign mem_wen   = d_win && d_wen && rst;

    // ---------------------------------------------------------------- burst counter
    // Counts D grants that happened while F was waiting; any F grant or an
    // idle F port restarts the allowance.
    unified_mem_arbiter_sat_counter #(
        .W   (BW),
        .MAX (BURST_MAX)
    ) u_burst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (f_win || !f_req),
        .inc (d_win && f_req),
        .cnt (burst_cnt)
    );

    // ---------------------------------------------------------------- read response
    always_comb begin
        resp_owner_d = OWN_NONE;
        if (f_win) begin
            resp_owner_d = OWN_F;
        end else if (d_win && !d_wen) begin
            resp_owner_d = OWN_D;
        end
    end

    // Async clear drops any response that was in flight when reset hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_owner_q <= OWN_NONE;
        end else begin
            resp_owner_q <= resp_owner_d;
        end
    end

    assign f_rvalid = (resp_owner_q == OWN_F);
    assign d_rvalid = (resp_owner_q == OWN_D);
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    // ---------------------------------------------------------------- stall counters
    unified_mem_arbiter_sat_counter #(
        .W (CW)
    ) u_f_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_f),
        .cnt (f_stall_cnt)
    );

    unified_mem_arbiter_sat_counter #(
        .W (CW)
    ) u_d_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_d),
        .cnt (d_stall_cnt)
    );

endmodule : unified_mem_arbiter

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port, one-cycle-read-latency memory between the instruction-fetch port (F) and the data-access port (D) of the pipelined core. It selects one request per cycle, drives the memory command, and routes the read data back to its owner one cycle later. It also raises per-port stall signals to the pipeline and keeps saturating stall counters for performance measurement.

Parameters:
AW, 16, address width (matches ISIZE)
DW, 16, data width (matches DSIZE)
D_BURST_MAX, 3, maximum consecutive D grants while F is pending before F is forced a grant (legal range 1..7)
CW, 16, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
f_req  in  1  fetch request (read only)
f_addr  in  AW  fetch address
f_gnt  out  1  fetch command accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  DW  fetch read data
d_req  in  1  data request
d_wen  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  data command accepted this cycle
d_rvalid  out  1  data read data valid (reads only)
d_rdata  out  DW  data read data
mem_wen  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after the address
stall_f  out  1  f_req & ~f_gnt
stall_d  out  1  d_req & ~d_gnt
f_stall_cnt  out  CW  cycles with stall_f high, saturating
d_stall_cnt  out  CW  cycles with stall_d high, saturating

Behaviour:
- Reset (rst = 0, asynchronous): burst counter = 0; resp_owner = NONE; all rvalid = 0; stall counters = 0. gnt, stall and mem_* are combinational from requests and are not reset-gated, except that mem_wen = 0 while rst = 0.
- Arbitration, evaluated each cycle T:
  - Only one requester: that requester wins.
  - Both requesting: D wins unless burst_cnt == D_BURST_MAX; in that case F wins.
  - No request: no grant; mem_wen = 0; mem_addr holds the D address.
- Winner's command is driven combinationally on mem_addr, mem_wen and mem_wdata in cycle T. The matching gnt is high in T. F always has mem_wen = 0.
- A requester holds req and its payload stable until it sees gnt. It may present a new request in T+1, so back-to-back issue is allowed at one command per cycle.
- Burst counter, updated at the clock edge:
  - D granted while f_req is high: increment, saturating at D_BURST_MAX.
  - F granted: clear.
  - f_req low: clear.
- Read response:
  - resp_owner register captures F, D-read or NONE at the end of T. A D write records NONE.
  - In T+1, the matching rvalid is high for exactly one cycle and its rdata = mem_rdata.
  - The non-owner's rdata holds 0.
- Stall counters: increment each cycle their stall is high and saturate at all-ones (no wrap).
- Reset asserted mid-operation: an in-flight read response is discarded and no rvalid is issued after reset releases.
- A write followed immediately by a read of the same address returns the new data. The memory provides write-first ordering, and the arbiter adds no bypass.
- Latency: grant 0 cycles (same cycle as request when uncontended); read data 1 cycle after grant.

Decomposition:
- The shared define include supplies the AW/DW defaults and the owner encoding constants OWN_NONE = 2'd0, OWN_F = 2'd1, OWN_D = 2'd2.
- One natural sub-module: sat_counter (width parameter, inc enable, asynchronous active-low clear). It is instanced twice for the stall counters; the burst counter may reuse it.

Test Plan:
- Reset, then F-only reads at 0x0000..0x0003: f_gnt high each cycle, f_rvalid each following cycle with mem contents, stall_f never high, f_stall_cnt = 0.
- F and D both held requesting reads for 8 cycles, D_BURST_MAX = 3: grant order D,D,D,F,D,D,D,F; stall_f high 6 cycles; f_stall_cnt = 6.
- D write 0xBEEF to 0x0010, next cycle D read of 0x0010: d_gnt both cycles, no d_rvalid after the write, d_rvalid with 0xBEEF after the read.
- Reset pulsed low in the cycle after an F grant: f_rvalid stays 0 after release; counters = 0; mem_wen = 0 during reset.
- D requests continuously with f_req low for 20 cycles: burst counter never forces F; d_gnt high every cycle; stall_d = 0.
- Force stall_f high for 2^CW + 5 cycles (CW = 4 variant): f_stall_cnt saturates at 0xF and does not wrap.
